// File: rtl/encoder_sequencer.sv
// Sequences one encode job at a time: start the encoder, collect its result or
// recover from a timeout, and buffer the chain-code bytes in a 16-entry FIFO.
`timescale 1ns/1ps
module encoder_sequencer #(
  parameter int TIMEOUT    = 20000,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_id,
  output logic        req_ready,
  output logic        enc_start,
  output logic        enc_reset,
  input  logic        enc_done,
  input  logic        enc_error,
  input  logic        enc_code_valid,
  input  logic [7:0]  enc_code,
  input  logic [7:0]  enc_primeter,
  input  logic [11:0] enc_area,
  input  logic [6:0]  enc_start_row,
  input  logic [6:0]  enc_start_col,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_id,
  output logic [1:0]  res_status,
  output logic [7:0]  res_primeter,
  output logic [11:0] res_area,
  output logic [6:0]  res_row,
  output logic [6:0]  res_col,
  output logic        code_valid,
  output logic [7:0]  code_data,
  input  logic        code_rd,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds while valid is high.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_RESULT  = 2'd3;

  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] RC_LAST = 16'(RST_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rc_q, rc_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  id_q, id_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  prim_q, prim_d;
  logic [11:0] area_q, area_d;
  logic [6:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;

  logic [7:0]  mem_q [16];
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;

  logic push_req, push, pop, drop, full, empty;

  always_comb begin
    full     = (count_q == 5'd16);
    empty    = (count_q == 5'd0);
    push_req = (state_q == S_RUN) && enc_code_valid;
    pop      = code_rd && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + {3'b0, push};
    rd_ptr_d = rd_ptr_q + {3'b0, pop};
    count_d  = count_q + {4'b0, push} - {4'b0, pop};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rc_d     = rc_q;
    ovf_d    = ovf_q | drop;
    id_d     = id_q;
    status_d = status_q;
    prim_d   = prim_q;
    area_d   = area_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          id_d    = req_id;
          cnt_d   = 16'd0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != TO_MAX) cnt_d = cnt_q + 16'd1;
        if (enc_error || enc_done) begin
          // A drop in the finishing cycle still marks the job as overflowed.
          if (enc_error)            status_d = 2'b01;
          else if (ovf_q || drop)   status_d = 2'b11;
          else                      status_d = 2'b00;
          prim_d  = enc_primeter;
          area_d  = enc_area;
          row_d   = enc_start_row;
          col_d   = enc_start_col;
          state_d = S_RESULT;
        end else if (cnt_q == TO_LAST) begin
          status_d = 2'b10;
          prim_d   = 8'd0;
          area_d   = 12'd0;
          row_d    = 7'd0;
          col_d    = 7'd0;
          rc_d     = 16'd0;
          state_d  = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rc_q == RC_LAST) state_d = S_RESULT;
        else                 rc_d    = rc_q + 16'd1;
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      rc_q     <= 16'd0;
      ovf_q    <= 1'b0;
      id_q     <= 4'd0;
      status_q <= 2'b00;
      prim_q   <= 8'd0;
      area_q   <= 12'd0;
      row_q    <= 7'd0;
      col_q    <= 7'd0;
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rc_q     <= rc_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
      status_q <= status_d;
      prim_q   <= prim_d;
      area_q   <= area_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_code;
  end

  assign req_ready    = (state_q == S_IDLE);
  assign enc_start    = (state_q == S_RUN);
  assign enc_reset    = (state_q == S_RECOVER);
  assign res_valid    = (state_q == S_RESULT);
  assign res_id       = id_q;
  assign res_status   = status_q;
  assign res_primeter = prim_q;
  assign res_area     = area_q;
  assign res_row      = row_q;
  assign res_col      = col_q;
  assign code_valid   = !empty;
  assign code_data    = mem_q[rd_ptr_q];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Randomized bench for encoder_sequencer: a job-level driver pushes expected
// results and code bytes into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_encoder_sequencer;

  localparam int TIMEOUT    = 50;
  localparam int RST_CYCLES = 2;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_REC = 2, PH_RES = 3;
  localparam int K_OK = 0, K_ERR = 1, K_BOTH = 2, K_TO = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_id = 4'd0;
  logic        req_ready, enc_start, enc_reset;
  logic        enc_done = 1'b0, enc_error = 1'b0;
  logic        enc_code_valid = 1'b0;
  logic [7:0]  enc_code = 8'd0;
  logic [7:0]  enc_primeter = 8'd0;
  logic [11:0] enc_area = 12'd0;
  logic [6:0]  enc_start_row = 7'd0, enc_start_col = 7'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_id;
  logic [1:0]  res_status;
  logic [7:0]  res_primeter;
  logic [11:0] res_area;
  logic [6:0]  res_row, res_col;
  logic        code_valid;
  logic [7:0]  code_data;
  logic        code_rd = 1'b0;
  logic [1:0]  dbg_state;

  encoder_sequencer #(.TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .enc_start(enc_start), .enc_reset(enc_reset),
    .enc_done(enc_done), .enc_error(enc_error), .enc_code_valid(enc_code_valid),
    .enc_code(enc_code), .enc_primeter(enc_primeter), .enc_area(enc_area),
    .enc_start_row(enc_start_row), .enc_start_col(enc_start_col),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_status(res_status), .res_primeter(res_primeter), .res_area(res_area),
    .res_row(res_row), .res_col(res_col), .code_valid(code_valid),
    .code_data(code_data), .code_rd(code_rd), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_code_q[$];
  logic [39:0] exp_res_q[$];
  int   exp_phase = PH_IDLE;
  bit   mon_en = 1'b0;
  bit   model_ovf = 1'b0;
  bit   p_push = 1'b0, p_drop = 1'b0;
  logic [7:0] p_byte = 8'd0;
  int   push_pct = 50, rd_pct = 40;
  bit   rd_run_only = 1'b0, final_push = 1'b1, fix_res = 1'b0;
  logic [7:0]  fx_p = 8'd0;
  logic [11:0] fx_a = 12'd0;
  logic [6:0]  fx_r = 7'd0, fx_c = 7'd0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: phase-level outputs, result payload while offered, FIFO reads.
  always @(negedge clk) begin
    logic [39:0] r;
    logic [7:0]  b;
    if (mon_en && !reset) begin
      check("req_ready", {39'b0, req_ready}, {39'b0, exp_phase == PH_IDLE});
      check("enc_start", {39'b0, enc_start}, {39'b0, exp_phase == PH_RUN});
      check("enc_reset", {39'b0, enc_reset}, {39'b0, exp_phase == PH_REC});
      check("res_valid", {39'b0, res_valid}, {39'b0, exp_phase == PH_RES});
      check("code_valid", {39'b0, code_valid}, {39'b0, exp_code_q.size() != 0});
      if (res_valid) begin
        if (exp_res_q.size() == 0) check("res_spurious", {39'b0, res_valid}, 40'd0);
        else begin
          check("res_fields", {res_id, res_status, res_primeter, res_area, res_row, res_col},
                exp_res_q[0]);
          if (res_ready) r = exp_res_q.pop_front();
        end
      end
      if (code_valid && code_rd) begin
        if (exp_code_q.size() == 0) check("code_spurious", {39'b0, code_valid}, 40'd0);
        else begin
          b = exp_code_q.pop_front();
          check("code_data", {32'b0, code_data}, {32'b0, b});
        end
      end
    end
  end

  task automatic drive_fifo(input bit in_run);
    bit pop;
    enc_code_valid = (int'($urandom_range(1, 100)) <= push_pct);
    enc_code       = 8'($urandom);
    code_rd        = (rd_run_only && !in_run) ? 1'b0 : (int'($urandom_range(1, 100)) <= rd_pct);
    pop    = code_rd && (exp_code_q.size() > 0);
    p_byte = enc_code;
    p_push = 1'b0;
    p_drop = 1'b0;
    if (in_run && enc_code_valid) begin
      if (exp_code_q.size() < 16 || pop) p_push = 1'b1;
      else                               p_drop = 1'b1;
    end
  endtask

  task automatic tick(input int nxt);
    @(posedge clk);
    if (p_push) exp_code_q.push_back(p_byte);
    if (p_drop) model_ovf = 1'b1;
    p_push = 1'b0;
    p_drop = 1'b0;
    exp_phase = nxt;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_fifo(1'b0);
      tick(PH_IDLE);
    end
  endtask

  task automatic rand_res();
    enc_primeter  = 8'($urandom);
    enc_area      = 12'($urandom);
    enc_start_row = 7'($urandom);
    enc_start_col = 7'($urandom);
  endtask

  task automatic run_job(input logic [3:0] id, input int kind, input int run_len, input int stall);
    logic [1:0] st;
    int save;
    model_ovf = 1'b0;
    req_valid = 1'b1;
    req_id = id;
    drive_fifo(1'b0);
    tick(PH_RUN);
    req_valid = 1'b0;
    if (kind == K_TO) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        rand_res();
        drive_fifo(1'b1);
        if (i == TIMEOUT - 1) exp_res_q.push_back({id, 2'b10, 34'd0});
        tick((i == TIMEOUT - 1) ? PH_REC : PH_RUN);
      end
      for (int r = 0; r < RST_CYCLES; r++) begin
        drive_fifo(1'b0);
        tick((r == RST_CYCLES - 1) ? PH_RES : PH_REC);
      end
    end else begin
      for (int i = 0; i < run_len; i++) begin
        rand_res();
        drive_fifo(1'b1);
        tick(PH_RUN);
      end
      rand_res();
      if (fix_res) begin
        enc_primeter = fx_p; enc_area = fx_a; enc_start_row = fx_r; enc_start_col = fx_c;
      end
      enc_error = (kind == K_ERR || kind == K_BOTH);
      enc_done  = (kind == K_OK || kind == K_BOTH);
      save = push_pct;
      if (!final_push) push_pct = 0;
      drive_fifo(1'b1);
      push_pct = save;
      if (enc_error)                st = 2'b01;
      else if (model_ovf || p_drop) st = 2'b11;
      else                          st = 2'b00;
      exp_res_q.push_back({id, st, enc_primeter, enc_area, enc_start_row, enc_start_col});
      tick(PH_RES);
      enc_done = 1'b0;
      enc_error = 1'b0;
    end
    // Hold off the result while the host keeps asking for a new job.
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      req_valid = 1'($urandom_range(0, 1));
      req_id = 4'($urandom);
      drive_fifo(1'b0);
      tick(PH_RES);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    drive_fifo(1'b0);
    tick(PH_IDLE);
    res_ready = 1'b0;
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int kind;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {39'b0, req_ready}, 40'd1);
    check("rst_enc_start", {39'b0, enc_start}, 40'd0);
    check("rst_enc_reset", {39'b0, enc_reset}, 40'd0);
    check("rst_res_valid", {39'b0, res_valid}, 40'd0);
    check("rst_res_fields", {res_id, res_status, res_primeter, res_area, res_row, res_col}, 40'd0);
    check("rst_code_valid", {39'b0, code_valid}, 40'd0);
    reset = 1'b0;
    exp_phase = PH_IDLE;
    mon_en = 1'b1;
    idle(2);

    // Five codes then done with fixed result fields; then read them back.
    push_pct = 100; rd_pct = 0; final_push = 1'b0; fix_res = 1'b1;
    fx_p = 8'd40; fx_a = 12'd100; fx_r = 7'd10; fx_c = 7'd12;
    run_job(4'd3, K_OK, 5, 1);
    fix_res = 1'b0; final_push = 1'b1;
    push_pct = 50; rd_pct = 100;
    idle(7);

    run_job(4'd4, K_BOTH, 3, 0);
    run_job(4'd5, K_TO, 0, 1);

    // Twenty pushes with no reads, then push+pop at full.
    push_pct = 100; rd_pct = 0; final_push = 1'b0;
    run_job(4'd6, K_OK, 20, 0);
    final_push = 1'b1;
    rd_run_only = 1'b1; rd_pct = 100;
    run_job(4'd7, K_OK, 6, 0);
    rd_run_only = 1'b0; push_pct = 0;
    idle(20);

    push_pct = 60; rd_pct = 30;
    run_job(4'd8, K_OK, 2, 10);
    run_job(4'd9, K_OK, TIMEOUT - 1, 0);
    run_job(4'd10, K_ERR, TIMEOUT - 1, 0);

    for (int j = 0; j < 20; j++) begin
      kind = int'($urandom_range(0, 9));
      kind = (kind <= 5) ? K_OK : (kind <= 7) ? K_ERR : (kind == 8) ? K_BOTH : K_TO;
      push_pct = int'($urandom_range(20, 90));
      rd_pct   = int'($urandom_range(0, 70));
      run_job(4'($urandom), kind, int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 3)));
    end

    // Reset in RUN after three pushes.
    push_pct = 100; rd_pct = 0;
    model_ovf = 1'b0;
    req_valid = 1'b1; req_id = 4'd11;
    drive_fifo(1'b0);
    tick(PH_RUN);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_fifo(1'b1);
      tick(PH_RUN);
    end
    enc_code_valid = 1'b0; code_rd = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", {39'b0, req_ready}, 40'd1);
    check("mid_rst_code_valid", {39'b0, code_valid}, 40'd0);
    check("mid_rst_enc_start", {39'b0, enc_start}, 40'd0);
    check("mid_rst_res_valid", {39'b0, res_valid}, 40'd0);
    exp_code_q.delete();
    exp_res_q.delete();
    exp_phase = PH_IDLE;
    #1 reset = 1'b0;
    idle(3);

    push_pct = 70; rd_pct = 40;
    run_job(4'd12, K_OK, 4, 2);

    push_pct = 0; rd_pct = 100;
    for (int i = 0; i < 40 && exp_code_q.size() != 0; i++) idle(1);
    idle(1);
    #4;
    check("final_code_valid", {39'b0, code_valid}, 40'd0);
    check("final_res_pending", 40'(exp_res_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
